// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter: shares the single D-cache port between the load path and the store-buffer drain
//  clk, rst                                  clock, synchronous active-high reset
//  ld_req/ld_addr/ld_size/flush              memory-stage load request, held until ld_done or flush
//  ld_done/ld_data                           1-cycle load completion pulse and registered data
//  sb_wenable/sb_addr/sb_value/sb_size       store-buffer head store
//  sb_full                                   store buffer full, forces store priority
//  store_success                             1-cycle pulse, head store written
//  cache_req/we/addr/wdata/size              held cache request, stable until cache_done
//  cache_done/cache_rdata                    cache completion and read data
module dcache_port_arbiter #(
   parameter int WORD_SIZE        = 32,
   parameter int WIDTH            = 32,
   parameter int SIZE_WRITE_WIDTH = 2,
   parameter int STARVE_LIMIT     = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        ld_req,
   input  logic [WIDTH-1:0]            ld_addr,
   input  logic [SIZE_WRITE_WIDTH-1:0] ld_size,
   input  logic                        flush,
   output logic                        ld_done,
   output logic [WORD_SIZE-1:0]        ld_data,
   input  logic                        sb_wenable,
   input  logic [WIDTH-1:0]            sb_addr,
   input  logic [WORD_SIZE-1:0]        sb_value,
   input  logic [SIZE_WRITE_WIDTH-1:0] sb_size,
   input  logic                        sb_full,
   output logic                        store_success,
   output logic                        cache_req,
   output logic                        cache_we,
   output logic [WIDTH-1:0]            cache_addr,
   output logic [WORD_SIZE-1:0]        cache_wdata,
   output logic [SIZE_WRITE_WIDTH-1:0] cache_size,
   input  logic                        cache_done,
   input  logic [WORD_SIZE-1:0]        cache_rdata
);
   localparam int CW = $clog2(STARVE_LIMIT + 1);
   typedef enum logic [1:0] {IDLE, LOAD, STORE, RESP} state_t;
   state_t          state;
   logic [CW-1:0]   starve_cnt;
   logic            kill;
   logic            ld_ok, store_pri, grant_st, grant_ld;
   always_comb begin
      ld_ok     = ld_req & ~flush;
      store_pri = sb_full | (starve_cnt >= CW'(STARVE_LIMIT));
      grant_st  = sb_wenable & (store_pri | ~ld_ok);
      grant_ld  = ~grant_st & ld_ok;
   end
   // pulses are raised on the cache_done edge so they are visible during the RESP cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         starve_cnt    <= '0;
         kill          <= 1'b0;
         ld_done       <= 1'b0;
         store_success <= 1'b0;
         cache_req     <= 1'b0;
         cache_we      <= 1'b0;
         ld_data       <= '0;
         cache_addr    <= '0;
         cache_wdata   <= '0;
         cache_size    <= '0;
      end else begin
         ld_done       <= 1'b0;
         store_success <= 1'b0;
         case (state)
            IDLE: begin
               kill <= 1'b0;
               if (grant_st | grant_ld) begin
                  cache_req   <= 1'b1;
                  cache_we    <= grant_st;
                  cache_addr  <= grant_st ? sb_addr : ld_addr;
                  cache_size  <= grant_st ? sb_size : ld_size;
                  cache_wdata <= sb_value;
                  state       <= grant_st ? STORE : LOAD;
               end
               if (grant_st)
                  starve_cnt <= '0;
               else if (grant_ld & sb_wenable & (starve_cnt < CW'(STARVE_LIMIT)))
                  starve_cnt <= starve_cnt + CW'(1);
            end
            LOAD: begin
               kill <= kill | flush;
               if (cache_done) begin
                  cache_req <= 1'b0;
                  ld_data   <= cache_rdata;
                  ld_done   <= ~(kill | flush);
                  state     <= RESP;
               end
            end
            STORE: begin
               if (cache_done) begin
                  cache_req     <= 1'b0;
                  store_success <= 1'b1;
                  state         <= RESP;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dcache_port_arbiter.sv
// tb_dcache_port_arbiter: table-driven directed vectors for dcache_port_arbiter
module tb_dcache_port_arbiter;
   logic        clk = 1'b0;
   logic        rst, ld_req, flush, sb_wenable, sb_full, cache_done;
   logic [31:0] ld_addr, sb_addr, sb_value, cache_rdata;
   logic [1:0]  ld_size, sb_size;
   logic        ld_done, store_success, cache_req, cache_we;
   logic [31:0] ld_data, cache_addr, cache_wdata;
   logic [1:0]  cache_size;
   int          vectors = 0;
   int          miscompares = 0;
   always #5 clk = ~clk;
   dcache_port_arbiter dut (
      .clk(clk), .rst(rst), .ld_req(ld_req), .ld_addr(ld_addr), .ld_size(ld_size), .flush(flush),
      .ld_done(ld_done), .ld_data(ld_data), .sb_wenable(sb_wenable), .sb_addr(sb_addr),
      .sb_value(sb_value), .sb_size(sb_size), .sb_full(sb_full), .store_success(store_success),
      .cache_req(cache_req), .cache_we(cache_we), .cache_addr(cache_addr), .cache_wdata(cache_wdata),
      .cache_size(cache_size), .cache_done(cache_done), .cache_rdata(cache_rdata)
   );
   typedef struct {
      logic        rst, lr, fl, sw, sf, cd;
      logic [31:0] la, sa, sv, rd;
      logic        e_req, e_we, e_ld, e_ss;
      logic [31:0] e_addr, e_data, e_wd;
   } vec_t;
   vec_t tbl[31];
   function automatic vec_t mk(logic r, logic lr, logic [31:0] la, logic fl, logic sw, logic [31:0] sa,
                               logic [31:0] sv, logic sf, logic cd, logic [31:0] rd, logic e_req,
                               logic e_we, logic [31:0] e_addr, logic e_ld, logic e_ss,
                               logic [31:0] e_data, logic [31:0] e_wd);
      vec_t v;
      v.rst = r; v.lr = lr; v.la = la; v.fl = fl; v.sw = sw; v.sa = sa; v.sv = sv; v.sf = sf;
      v.cd = cd; v.rd = rd; v.e_req = e_req; v.e_we = e_we; v.e_addr = e_addr; v.e_ld = e_ld;
      v.e_ss = e_ss; v.e_data = e_data; v.e_wd = e_wd;
      return v;
   endfunction
   task automatic chk(string n, logic [31:0] a, logic [31:0] e);
      if (a !== e) begin
         miscompares++;
         $display("FAIL %s at vector %0d: got %h expected %h", n, vectors, a, e);
      end
   endtask
   task automatic apply(vec_t v);
      @(negedge clk);
      rst = v.rst; ld_req = v.lr; ld_addr = v.la; flush = v.fl; sb_wenable = v.sw;
      sb_addr = v.sa; sb_value = v.sv; sb_full = v.sf; cache_done = v.cd; cache_rdata = v.rd;
      @(posedge clk);
      #1;
      vectors++;
      chk("cache_req", 32'(cache_req), 32'(v.e_req));
      chk("cache_addr", cache_addr, v.e_addr);
      chk("ld_done", 32'(ld_done), 32'(v.e_ld));
      chk("store_success", 32'(store_success), 32'(v.e_ss));
      chk("ld_data", ld_data, v.e_data);
      if (v.e_req || v.rst) chk("cache_we", 32'(cache_we), 32'(v.e_we));
      if (v.e_req) chk("cache_size", 32'(cache_size), v.e_we ? 32'd2 : 32'd1);
      if (v.e_req && v.e_we) chk("cache_wdata", cache_wdata, v.e_wd);
      if (v.rst) begin
         chk("rst_wdata", cache_wdata, 32'd0);
         chk("rst_size", 32'(cache_size), 32'd0);
      end
   endtask
   initial begin
      ld_size = 2'd1; sb_size = 2'd2;
      //            rst lr la        fl sw sa       sv            sf cd rd              req we addr     ld ss data          wd
      tbl[0]  = mk(1, 0, 0,         0, 0, 0,       0,            0, 0, 0,            0, 0, 0,       0, 0, 0,            0);
      tbl[1]  = mk(0, 1, 32'h100,   0, 0, 0,       0,            0, 0, 0,            1, 0, 32'h100, 0, 0, 0,            0);
      tbl[2]  = mk(0, 1, 32'h100,   0, 0, 0,       0,            0, 1, 32'hDEADBEEF, 0, 0, 32'h100, 1, 0, 32'hDEADBEEF, 0);
      tbl[3]  = mk(0, 0, 0,         0, 0, 0,       0,            0, 0, 0,            0, 0, 32'h100, 0, 0, 32'hDEADBEEF, 0);
      tbl[4]  = mk(0, 0, 0,         0, 1, 32'h40,  32'h12345678, 0, 0, 0,            1, 1, 32'h40,  0, 0, 32'hDEADBEEF, 32'h12345678);
      tbl[5]  = mk(0, 0, 0,         0, 1, 32'h40,  32'h12345678, 0, 1, 0,            0, 1, 32'h40,  0, 1, 32'hDEADBEEF, 0);
      tbl[6]  = mk(0, 0, 0,         0, 0, 0,       0,            0, 0, 0,            0, 0, 32'h40,  0, 0, 32'hDEADBEEF, 0);
      tbl[7]  = mk(0, 0, 0,         0, 0, 0,       0,            0, 0, 0,            0, 0, 32'h40,  0, 0, 32'hDEADBEEF, 0);
      tbl[8]  = mk(0, 1, 32'h200,   0, 1, 32'h80,  32'hA5A5A5A5, 1, 0, 0,            1, 1, 32'h80,  0, 0, 32'hDEADBEEF, 32'hA5A5A5A5);
      tbl[9]  = mk(0, 1, 32'h200,   0, 1, 32'h80,  32'hA5A5A5A5, 1, 1, 0,            0, 1, 32'h80,  0, 1, 32'hDEADBEEF, 0);
      tbl[10] = mk(0, 1, 32'h200,   0, 0, 0,       0,            0, 0, 0,            0, 0, 32'h80,  0, 0, 32'hDEADBEEF, 0);
      tbl[11] = mk(0, 1, 32'h200,   0, 0, 0,       0,            0, 0, 0,            1, 0, 32'h200, 0, 0, 32'hDEADBEEF, 0);
      tbl[12] = mk(0, 1, 32'h200,   0, 0, 0,       0,            0, 1, 32'hCAFEF00D, 0, 0, 32'h200, 1, 0, 32'hCAFEF00D, 0);
      tbl[13] = mk(0, 0, 0,         0, 0, 0,       0,            0, 0, 0,            0, 0, 32'h200, 0, 0, 32'hCAFEF00D, 0);
      tbl[14] = mk(0, 1, 32'h300,   0, 0, 0,       0,            0, 0, 0,            1, 0, 32'h300, 0, 0, 32'hCAFEF00D, 0);
      tbl[15] = mk(0, 0, 0,         1, 0, 0,       0,            0, 0, 0,            1, 0, 32'h300, 0, 0, 32'hCAFEF00D, 0);
      tbl[16] = mk(0, 0, 0,         0, 0, 0,       0,            0, 0, 0,            1, 0, 32'h300, 0, 0, 32'hCAFEF00D, 0);
      tbl[17] = mk(0, 0, 0,         0, 0, 0,       0,            0, 1, 32'h11112222, 0, 0, 32'h300, 0, 0, 32'h11112222, 0);
      tbl[18] = mk(0, 0, 0,         0, 1, 32'h44,  32'h55,       0, 0, 0,            0, 0, 32'h300, 0, 0, 32'h11112222, 0);
      tbl[19] = mk(0, 0, 0,         0, 1, 32'h44,  32'h55,       0, 0, 0,            1, 1, 32'h44,  0, 0, 32'h11112222, 32'h55);
      tbl[20] = mk(0, 0, 0,         0, 1, 32'h44,  32'h55,       0, 1, 0,            0, 1, 32'h44,  0, 1, 32'h11112222, 0);
      tbl[21] = mk(0, 0, 0,         0, 0, 0,       0,            0, 0, 0,            0, 0, 32'h44,  0, 0, 32'h11112222, 0);
      tbl[22] = mk(0, 1, 32'h400,   1, 0, 0,       0,            0, 0, 0,            0, 0, 32'h44,  0, 0, 32'h11112222, 0);
      tbl[23] = mk(0, 1, 32'h400,   0, 0, 0,       0,            0, 0, 0,            1, 0, 32'h400, 0, 0, 32'h11112222, 0);
      tbl[24] = mk(0, 0, 0,         1, 0, 0,       0,            0, 1, 32'h77,       0, 0, 32'h400, 0, 0, 32'h77,       0);
      tbl[25] = mk(0, 0, 0,         0, 0, 0,       0,            0, 0, 0,            0, 0, 32'h400, 0, 0, 32'h77,       0);
      tbl[26] = mk(0, 0, 0,         0, 1, 32'h60,  32'h9,        0, 0, 0,            1, 1, 32'h60,  0, 0, 32'h77,       32'h9);
      tbl[27] = mk(0, 0, 0,         0, 0, 0,       0,            0, 0, 0,            1, 1, 32'h60,  0, 0, 32'h77,       32'h9);
      tbl[28] = mk(1, 0, 0,         0, 1, 32'h60,  32'h9,        0, 0, 0,            0, 0, 0,       0, 0, 0,            0);
      tbl[29] = mk(0, 0, 0,         0, 0, 0,       0,            0, 1, 32'hFFFF,     0, 0, 0,       0, 0, 0,            0);
      tbl[30] = mk(0, 0, 0,         0, 0, 0,       0,            0, 0, 0,            0, 0, 0,       0, 0, 0,            0);
      foreach (tbl[i]) apply(tbl[i]);
      // starvation: load and store both held, four loads win before the store is forced
      for (int k = 0; k < 4; k++) begin
         apply(mk(0, 1, 32'h500, 0, 1, 32'h600, 32'hBEEF, 0, 0, 0,        1, 0, 32'h500, 0, 0, 32'(k), 0));
         apply(mk(0, 1, 32'h500, 0, 1, 32'h600, 32'hBEEF, 0, 1, 32'(k+1), 0, 0, 32'h500, 1, 0, 32'(k+1), 0));
         apply(mk(0, 1, 32'h500, 0, 1, 32'h600, 32'hBEEF, 0, 0, 0,        0, 0, 32'h500, 0, 0, 32'(k+1), 0));
      end
      apply(mk(0, 1, 32'h500, 0, 1, 32'h600, 32'hBEEF, 0, 0, 0, 1, 1, 32'h600, 0, 0, 32'd4, 32'hBEEF));
      apply(mk(0, 1, 32'h500, 0, 1, 32'h600, 32'hBEEF, 0, 1, 0, 0, 1, 32'h600, 0, 1, 32'd4, 0));
      apply(mk(0, 1, 32'h500, 0, 1, 32'h700, 32'hF00, 0, 0, 0, 0, 0, 32'h600, 0, 0, 32'd4, 0));
      // counter was cleared by the store grant, so the load wins again
      apply(mk(0, 1, 32'h500, 0, 1, 32'h700, 32'hF00, 0, 0, 0, 1, 0, 32'h500, 0, 0, 32'd4, 0));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
